// File: rtl/shift_pkg.sv
// Shared types for the multi-cycle logarithmic shifter: shift modes,
// controller states and a constant clog2 helper for counter sizing.
package shift_pkg;

    typedef enum logic [1:0] {
        MODE_SLL = 2'd0,
        MODE_SRL = 2'd1,
        MODE_SRA = 2'd2,
        MODE_ROL = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Ceiling log2 usable in constant expressions; clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// Single combinational shifter stage: shifts/rotates data_i by amt_i
// (a one-hot power of two) when en_i is set, otherwise passes it through.
// Ports: data_i operand, amt_i shift distance, en_i stage enable,
//        mode_i SLL/SRL/SRA/ROL select, data_o result.
// Rotate wrap logic exists only with SHIFT_LOG_MULTI_ROTATE_EN defined;
// otherwise ROL decodes as SLL.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 256,
    parameter int AW    = 8
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [AW-1:0]    amt_i,
    input  logic             en_i,
    input  mode_e            mode_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] sll;
    logic [WIDTH-1:0] srl;
    logic [WIDTH-1:0] sra;

    assign sll = data_i << amt_i;
    assign srl = data_i >> amt_i;
    assign sra = $signed(data_i) >>> amt_i;

`ifdef SHIFT_LOG_MULTI_ROTATE_EN
    logic [WIDTH-1:0] rol;

    // amt_i is always below WIDTH, so the wrap shift is in 1..WIDTH-1.
    assign rol = sll | (data_i >> (WIDTH - int'(amt_i)));
`endif

    always_comb begin
        data_o = data_i;
        if (en_i) begin
            unique case (mode_i)
                MODE_SRL: data_o = srl;
                MODE_SRA: data_o = sra;
`ifdef SHIFT_LOG_MULTI_ROTATE_EN
                MODE_ROL: data_o = rol;
`endif
                default:  data_o = sll;
            endcase
        end
    end

endmodule

// File: rtl/shift_log_multi.sv
// Multi-cycle logarithmic shifter: one shift_stage reused for LOGW cycles,
// stage i applying a 2^i shift when bit i of the captured amount is set.
// Ports: clock, reset (sync, active-high), start/ready handshake,
//        mode (SLL/SRL/SRA/ROL), in operand, shift amount,
//        out result register, done one-cycle result-valid pulse.
// Macro SHIFT_LOG_MULTI_ROTATE_EN enables mode 3 rotate; else mode 3 = SLL.
module shift_log_multi
    import shift_pkg::*;
#(
    parameter  int WIDTH = 256,
    localparam int LOGW  = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] in,
    input  logic [LOGW-1:0]  shift,
    output logic [WIDTH-1:0] out,
    output logic             ready,
    output logic             done
);

    localparam int CW = (clog2(LOGW) > 0) ? clog2(LOGW) : 1;
    localparam logic [CW-1:0] LAST = CW'(LOGW - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [WIDTH-1:0] out_q,   out_d;
    logic [LOGW-1:0]  amt_q,   amt_d;
    mode_e            mode_q,  mode_d;
    logic             done_q,  done_d;

    logic [LOGW-1:0]  stage_amt;
    logic             stage_en;
    logic [WIDTH-1:0] stage_out;

    // Stage distance is 2^cnt; it fires only if that amount bit is set.
    assign stage_amt = LOGW'(1) << cnt_q;
    assign stage_en  = |(amt_q & stage_amt);

    shift_stage #(
        .WIDTH (WIDTH),
        .AW    (LOGW)
    ) u_stage (
        .data_i (data_q),
        .amt_i  (stage_amt),
        .en_i   (stage_en),
        .mode_i (mode_q),
        .data_o (stage_out)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        out_d   = out_q;
        amt_d   = amt_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    data_d  = in;
                    amt_d   = shift;
                    mode_d  = mode_e'(mode);
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                data_d = stage_out;
                if (cnt_q == LAST) begin
                    out_d   = stage_out;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            out_q   <= '0;
            amt_q   <= '0;
            mode_q  <= MODE_SLL;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            out_q   <= out_d;
            amt_q   <= amt_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    assign out   = out_q;
    assign done  = done_q;
    assign ready = (state_q == ST_IDLE);

endmodule

// File: tb/tb_shift_log_multi.sv
// Scoreboard bench for shift_log_multi: WIDTH=256 random/directed traffic
// plus a WIDTH=200 instance for non-power-of-two boundary cases.
module tb_shift_log_multi;

    localparam int W  = 256;
    localparam int LW = 8;
    localparam int W2 = 200;

    typedef struct {
        logic [W-1:0] res;
        int           acc;
        bit           b2b;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic [1:0]    mode_v;
    logic [W-1:0]  in_v;
    logic [LW-1:0] sh_v;
    logic [W-1:0]  out_v;
    logic          ready;
    logic          done;

    logic          start2;
    logic [1:0]    mode2;
    logic [W2-1:0] in2;
    logic [7:0]    sh2;
    logic [W2-1:0] out2;
    logic          ready2;
    logic          done2;

    int   cyc;
    int   total;
    int   bad;
    int   next_free;
    int   last_done;
    bit   b2b_tag;
    exp_t q[$];

    shift_log_multi #(.WIDTH(W)) u_dut (
        .clock (clk),
        .reset (rst),
        .start (start),
        .mode  (mode_v),
        .in    (in_v),
        .shift (sh_v),
        .out   (out_v),
        .ready (ready),
        .done  (done)
    );

    shift_log_multi #(.WIDTH(W2)) u_dut200 (
        .clock (clk),
        .reset (rst),
        .start (start2),
        .mode  (mode2),
        .in    (in2),
        .shift (sh2),
        .out   (out2),
        .ready (ready2),
        .done  (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: result of shifting by the whole amount at once.
    function automatic logic [W-1:0] model(input logic [W-1:0] x,
                                           input int s,
                                           input logic [1:0] m);
        logic [W-1:0] r;
        int k;
        case (m)
            2'd1: r = (s >= W) ? '0 : (x >> s);
            2'd2: begin
                r = (s >= W) ? '0 : (x >> s);
                if (x[W-1])
                    for (int i = 0; i < W; i++)
                        if (i >= W - s) r[i] = 1'b1;
            end
            2'd3: begin
`ifdef SHIFT_LOG_MULTI_ROTATE_EN
                k = s % W;
                r = (x << k) | (x >> (W - k));
`else
                k = s;
                r = (k >= W) ? '0 : (x << k);
`endif
            end
            default: r = (s >= W) ? '0 : (x << s);
        endcase
        return r;
    endfunction

    function automatic logic [W-1:0] rand256();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // One negedge of stimulus; the bench's own idea of when the DUT is
    // free decides whether a start counts as an accepted request.
    task automatic step(input logic s, input logic [W-1:0] x,
                        input logic [LW-1:0] sh, input logic [1:0] m);
        bit free;
        @(negedge clk);
        free = (cyc + 1 >= next_free);
        total++;
        if (ready !== free) begin
            bad++;
            $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, ready, free);
        end
        start  = s;
        in_v   = x;
        sh_v   = sh;
        mode_v = m;
        if (s && free) begin
            q.push_back('{model(x, int'(sh), m), cyc + 1, b2b_tag});
            next_free = cyc + 1 + LW + 1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            step(1'b0, rand256(), LW'($urandom), 2'($urandom));
            n++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain timeout pending=%0d exp=0", q.size());
            q.delete();
        end
        step(1'b0, '0, '0, '0);
    endtask

    // Monitor: every done must match the oldest outstanding request.
    initial begin
        exp_t e;
        last_done = -100;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_done cyc=%0d out=%h", cyc, out_v);
                end else begin
                    e = q.pop_front();
                    if (out_v !== e.res) begin
                        bad++;
                        $display("FAIL result got=%h exp=%h", out_v, e.res);
                    end
                    total++;
                    if (cyc + 1 - e.acc != LW + 1) begin
                        bad++;
                        $display("FAIL latency got=%0d exp=%0d",
                                 cyc + 1 - e.acc, LW + 1);
                    end
                    if (e.b2b) begin
                        total++;
                        if (cyc - last_done != LW + 1) begin
                            bad++;
                            $display("FAIL done_spacing got=%0d exp=%0d",
                                     cyc - last_done, LW + 1);
                        end
                    end
                end
                last_done = cyc;
            end
        end
    end

    task automatic check200(input string name, input logic [W2-1:0] x,
                            input logic [7:0] sh, input logic [1:0] m,
                            input logic [W2-1:0] exp);
        int c0;
        int n;
        @(negedge clk);
        start2 = 1'b1;
        in2    = x;
        sh2    = sh;
        mode2  = m;
        c0     = cyc + 1;
        @(negedge clk);
        start2 = 1'b0;
        n = 0;
        while (done2 !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (done2 !== 1'b1) begin
            bad++;
            $display("FAIL %s timeout done=%b exp=1", name, done2);
        end else begin
            if (out2 !== exp) begin
                bad++;
                $display("FAIL %s got=%h exp=%h", name, out2, exp);
            end
            total++;
            if (cyc + 1 - c0 != 9) begin
                bad++;
                $display("FAIL %s latency got=%0d exp=9", name, cyc + 1 - c0);
            end
        end
    endtask

    initial begin
        logic [W-1:0]  x;
        logic [W-1:0]  one;
        logic [W2-1:0] e2;
        logic [W2-1:0] i2;
        total     = 0;
        bad       = 0;
        next_free = 0;
        b2b_tag   = 1'b0;
        rst       = 1'b1;
        start     = 1'b0;
        mode_v    = '0;
        in_v      = '0;
        sh_v      = '0;
        start2    = 1'b0;
        mode2     = '0;
        in2       = '0;
        sh2       = '0;

        repeat (3) @(negedge clk);
        total += 3;
        if (out_v !== '0) begin
            bad++;
            $display("FAIL reset_out got=%h exp=0", out_v);
        end
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%b exp=1", ready);
        end
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL reset_done got=%b exp=0", done);
        end
        rst = 1'b0;

        one = '0;
        one[0] = 1'b1;
        step(1'b1, one, 8'd255, 2'd0);
        drain();
        x = '0;
        x[W-1] = 1'b1;
        step(1'b1, x, 8'd4, 2'd2);
        drain();
        step(1'b1, x, 8'd4, 2'd1);
        drain();
        x = 256'hF;
        step(1'b1, x, 8'd2, 2'd3);
        drain();
        x = rand256();
        step(1'b1, x, 8'd0, 2'd2);
        drain();

        // Start held high: only every LOGW+1 cycles is it accepted, and
        // the inputs changing in between must be ignored.
        for (int n = 0; n < 3 * (LW + 1); n++) begin
            step(1'b1, rand256(), LW'($urandom), 2'($urandom));
            b2b_tag = 1'b1;
        end
        b2b_tag = 1'b0;
        drain();

        for (int n = 0; n < 300; n++) begin
            logic [LW-1:0] s;
            s = LW'($urandom);
            if ($urandom_range(0, 3) == 0) s = ($urandom_range(0, 1) == 1) ? 8'd255 : 8'd0;
            x = rand256();
            if ($urandom_range(0, 1) == 1) x[W-1] = 1'b1;
            step(1'($urandom_range(0, 1)), x, s, 2'($urandom));
        end
        drain();

        // Abort in the third RUN cycle.
        step(1'b1, rand256(), 8'd37, 2'd1);
        step(1'b0, '0, '0, '0);
        step(1'b0, '0, '0, '0);
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        total += 3;
        if (out_v !== '0) begin
            bad++;
            $display("FAIL abort_out got=%h exp=0", out_v);
        end
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL abort_ready got=%b exp=1", ready);
        end
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL abort_done got=%b exp=0", done);
        end
        next_free = cyc + 1;
        repeat (12) step(1'b0, '0, '0, '0);
        x = rand256();
        step(1'b1, x, 8'd0, 2'($urandom));
        drain();

        i2 = 200'b1011;
        e2 = '0;
        e2[W2-1] = 1'b1;
`ifdef SHIFT_LOG_MULTI_ROTATE_EN
        e2[2:0] = 3'b101;
`endif
        check200("w200_rol199", i2, 8'd199, 2'd3, e2);
        e2 = '0;
        check200("w200_sll200", i2, 8'd200, 2'd0, e2);
        i2 = '0;
        i2[W2-1] = 1'b1;
        e2 = '1;
        check200("w200_sra200", i2, 8'd200, 2'd2, e2);
        i2 = '1;
        e2 = '0;
        check200("w200_srl250", i2, 8'd250, 2'd1, e2);
        i2 = 200'b1011;
`ifdef SHIFT_LOG_MULTI_ROTATE_EN
        e2 = i2 << 50;
`else
        e2 = '0;
`endif
        check200("w200_rol250", i2, 8'd250, 2'd3, e2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_log_multi.md
SHIFT_LOG_MULTI -- requirements
Module: shift_log_multi

Interface
REQ-001 The block SHALL have parameter WIDTH, default 256, giving the data width; any value 2..1024 is legal, including non-powers-of-two.
REQ-002 The block SHALL have derived localparam LOGW = $clog2(WIDTH), giving the shift-amount width and the stage count.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request strobe, sampled only while ready=1.
REQ-006 The block SHALL have port mode, input, 2 bits: 0=SLL, 1=SRL, 2=SRA, 3=ROL.
REQ-007 The block SHALL have port in, input, WIDTH bits: the operand.
REQ-008 The block SHALL have port shift, input, LOGW bits: the shift amount.
REQ-009 The block SHALL have port out, output, WIDTH bits: the result register, held stable between done and the next accepted start.
REQ-010 The block SHALL have port ready, output, 1 bit: high when idle and able to accept start.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse marking out valid.

Function
REQ-012 The block SHALL implement FSM states IDLE and RUN.
REQ-013 In IDLE with start=1, the block SHALL capture in, shift and mode, clear the stage counter, and enter RUN; ready SHALL go low on the next cycle.
REQ-014 RUN SHALL last exactly LOGW cycles; stage i (i=0..LOGW-1) SHALL apply a shift/rotate of 2^i when captured shift[i]=1 and SHALL otherwise hold the value, so timing is independent of the data and the amount.
REQ-015 On leaving RUN the block SHALL return to IDLE, pulse done for one cycle, and raise ready in the same cycle; latency from the start-sampled edge to done SHALL be LOGW+1 cycles.
REQ-016 start while ready=0 SHALL be ignored, and in, shift and mode SHALL not be resampled.
REQ-017 start asserted in the same cycle that done pulses SHALL be accepted, giving back-to-back throughput of one result per LOGW+1 cycles.
REQ-018 SLL and SRL SHALL zero-fill; SRA SHALL fill with captured in[WIDTH-1]; ROL SHALL rotate left with wrap-around.
REQ-019 If shift>=WIDTH (non-power-of-two WIDTH), SLL and SRL SHALL yield 0, SRA SHALL yield all copies of the sign bit, and ROL SHALL yield a rotate by shift mod WIDTH.
REQ-020 shift=0 SHALL return in unchanged, with the same LOGW+1 latency.

Reset
REQ-021 reset=1 SHALL force IDLE, out=0, done=0, ready=1 at the next edge, and SHALL take priority over start.
REQ-022 Reset during RUN SHALL abort the operation with no done pulse; a start after reset deasserts SHALL behave normally.

Configuration
REQ-023 With macro SHIFT_LOG_MULTI_ROTATE_EN defined, mode 3 SHALL perform ROL per REQ-018 and REQ-019.
REQ-024 Without SHIFT_LOG_MULTI_ROTATE_EN, mode 3 SHALL behave exactly as SLL, and no rotate wrap logic SHALL be synthesised.

Structure
REQ-025 A shared package shift_pkg SHALL hold the mode enum (MODE_SLL, MODE_SRL, MODE_SRA, MODE_ROL), the FSM state enum, and a clog2 helper constant function.
REQ-026 The block SHALL use one sub-module, shift_stage, parametrised by WIDTH: combinational single-stage shift by a run-time amount 2^i with a mode select, instantiated once and indexed by the stage counter.

Verification
REQ-027 WIDTH=256, SLL, in=1, shift=255 SHALL give out=1<<255 and done exactly 9 cycles after start.
REQ-028 WIDTH=256, SRA, in=0x8000...0000, shift=4 SHALL give out=0xF800...0000; the same case with SRL SHALL give 0x0800...0000.
REQ-029 WIDTH=200 with ROTATE_EN, ROL, in=0b1011, shift=199 SHALL give bit 199=1, bits 0..2=0b101; the same case with SLL and shift=200 SHALL give 0.
REQ-030 The bench SHALL assert start continuously for 3 operations and check that done is spaced every LOGW+1 cycles and that starts sampled while ready=0 have no effect.
REQ-031 Reset asserted at RUN cycle 3 SHALL produce no done pulse, out=0 and ready=1 next cycle; a subsequent shift=0 SHALL return in after LOGW+1 cycles.
REQ-032 Without ROTATE_EN, mode=3, in=0xF, shift=2 SHALL give 0x3C.
